// File: rtl/snitch_icache_miss_handler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | snitch_icache_miss_handler                                                |
// | Consumes the icache lookup stream: hits go straight to the fetch response |
// | port, misses are merged per cache line in a small pending table that      |
// | issues one refill per line and, on refill return, writes the line into    |
// | the lookup stage and answers all merged requesters at once.               |
// |                                                                           |
// | Ports                                                                     |
// |   clk_i / rst_ni     clock, asynchronous active-low reset                 |
// |   in_*               lookup result stream (valid/ready)                   |
// |   rsp_*              fetch response (valid/ready, id may be multi-hot)    |
// |   refill_addr/id_o   refill request (valid/ready)                         |
// |   refill_data/...    refill return (valid/ready)                          |
// |   write_*            line write into the lookup stage (valid/ready)       |
// |                                                                           |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+

package snitch_icache_pkg;
  typedef struct packed {
    int unsigned FETCH_AW;
    int unsigned ID_WIDTH;
    int unsigned LINE_WIDTH;
    int unsigned LINE_ALIGN;
    int unsigned COUNT_ALIGN;
    int unsigned SET_ALIGN;
    int unsigned SET_COUNT;
    int unsigned TAG_WIDTH;
    int unsigned PENDING_COUNT;
  } config_t;

  localparam config_t DEFAULT_CFG = '{
    FETCH_AW: 32, ID_WIDTH: 4, LINE_WIDTH: 128, LINE_ALIGN: 4, COUNT_ALIGN: 4,
    SET_ALIGN: 1, SET_COUNT: 2, TAG_WIDTH: 24, PENDING_COUNT: 2
  };
endpackage

module snitch_icache_miss_handler #(
  parameter snitch_icache_pkg::config_t CFG = snitch_icache_pkg::DEFAULT_CFG,
  localparam int unsigned PENDING_IW =
    (CFG.PENDING_COUNT > 1) ? $clog2(CFG.PENDING_COUNT) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  // lookup stage result
  input  logic [CFG.FETCH_AW-1:0]     in_addr_i,
  input  logic [CFG.ID_WIDTH-1:0]     in_id_i,
  input  logic [CFG.SET_ALIGN-1:0]    in_set_i,
  input  logic                        in_hit_i,
  input  logic [CFG.LINE_WIDTH-1:0]   in_data_i,
  input  logic                        in_error_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  // fetch response
  output logic [CFG.FETCH_AW-1:0]     rsp_addr_o,
  output logic [CFG.ID_WIDTH-1:0]     rsp_id_o,
  output logic [CFG.LINE_WIDTH-1:0]   rsp_data_o,
  output logic                        rsp_error_o,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  // refill request
  output logic [CFG.FETCH_AW-1:0]     refill_addr_o,
  output logic [PENDING_IW-1:0]       refill_id_o,
  output logic                        refill_valid_o,
  input  logic                        refill_ready_i,
  // refill return
  input  logic [CFG.LINE_WIDTH-1:0]   refill_data_i,
  input  logic                        refill_error_i,
  input  logic [PENDING_IW-1:0]       refill_id_i,
  input  logic                        refill_valid_i,
  output logic                        refill_ready_o,
  // line write into the lookup stage
  output logic [CFG.COUNT_ALIGN-1:0]  write_addr_o,
  output logic [CFG.SET_ALIGN-1:0]    write_set_o,
  output logic [CFG.LINE_WIDTH-1:0]   write_data_o,
  output logic [CFG.TAG_WIDTH-1:0]    write_tag_o,
  output logic                        write_error_o,
  output logic                        write_valid_o,
  input  logic                        write_ready_i
);

  localparam int unsigned PENDING_COUNT = CFG.PENDING_COUNT;
  localparam int unsigned ID_WIDTH      = CFG.ID_WIDTH;
  localparam int unsigned LINE_ALIGN    = CFG.LINE_ALIGN;
  localparam int unsigned COUNT_ALIGN   = CFG.COUNT_ALIGN;
  localparam int unsigned SET_ALIGN     = CFG.SET_ALIGN;
  localparam int unsigned SET_COUNT     = CFG.SET_COUNT;
  localparam int unsigned LINE_AW       = CFG.FETCH_AW - CFG.LINE_ALIGN;

  // pending table
  logic [PENDING_COUNT-1:0] valid_q;
  logic [PENDING_COUNT-1:0] issued_q;
  logic [LINE_AW-1:0]       line_q [PENDING_COUNT];
  logic [ID_WIDTH-1:0]      id_q   [PENDING_COUNT];
  logic [SET_ALIGN-1:0]     evict_q;

  // A presented refill request that was not accepted is pinned to its entry,
  // so a lower-index entry allocated meanwhile cannot change the payload.
  logic                     hold_q;
  logic [PENDING_IW-1:0]    hold_idx_q;

  logic [LINE_AW-1:0]       in_line;
  logic                     retire;
  logic                     retire_known;
  logic [LINE_AW-1:0]       ret_line;
  logic [ID_WIDTH-1:0]      ret_id;
  logic [PENDING_COUNT-1:0] ret_sel;
  logic [PENDING_COUNT-1:0] match_vec;
  logic [PENDING_COUNT-1:0] alloc_sel;
  logic                     free_found;
  logic                     issue_found;
  logic [PENDING_IW-1:0]    issue_idx;
  logic [LINE_AW-1:0]       issue_line;
  logic                     is_hit;
  logic                     is_miss;
  logic                     accept_miss;
  logic                     do_merge;
  logic                     do_alloc;
  logic                     issue_hs;

  assign in_line = in_addr_i[CFG.FETCH_AW-1:LINE_ALIGN];
  assign retire  = refill_valid_i & write_ready_i & rsp_ready_i;

  always_comb begin
    ret_sel     = '0;
    ret_line    = '0;
    ret_id      = '0;
    match_vec   = '0;
    alloc_sel   = '0;
    free_found  = 1'b0;
    issue_found = 1'b0;
    issue_idx   = '0;
    issue_line  = '0;
    if (hold_q) begin
      issue_found = 1'b1;
      issue_idx   = hold_idx_q;
    end
    for (int i = 0; i < PENDING_COUNT; i++) begin
      if (refill_id_i == PENDING_IW'(i)) begin
        ret_sel[i] = 1'b1;
        ret_line   = line_q[i];
        ret_id     = id_q[i];
      end
      match_vec[i] = valid_q[i] && (line_q[i] == in_line);
      if (!valid_q[i] && !free_found) begin
        free_found   = 1'b1;
        alloc_sel[i] = 1'b1;
      end
      if (!hold_q && valid_q[i] && !issued_q[i] && !issue_found) begin
        issue_found = 1'b1;
        issue_idx   = PENDING_IW'(i);
      end
    end
    for (int i = 0; i < PENDING_COUNT; i++) begin
      if (issue_idx == PENDING_IW'(i)) issue_line = line_q[i];
    end
  end

  assign retire_known = |(ret_sel & valid_q & issued_q);

  // A retire owns both the response port and the table for this cycle.
  assign is_hit      = in_valid_i &  in_hit_i & ~retire;
  assign is_miss     = in_valid_i & ~in_hit_i & ~retire;
  assign accept_miss = is_miss & ((|match_vec) | free_found);
  assign do_merge    = accept_miss &  (|match_vec);
  assign do_alloc    = accept_miss & ~(|match_vec);
  assign in_ready_o  = is_hit ? rsp_ready_i : accept_miss;
  assign issue_hs    = issue_found & refill_ready_i;

  // response: retiring line takes precedence over a hit pass-through
  assign rsp_valid_o = retire | is_hit;
  assign rsp_addr_o  = retire ? {ret_line, {LINE_ALIGN{1'b0}}} : in_addr_i;
  assign rsp_id_o    = retire ? ret_id : in_id_i;
  assign rsp_data_o  = retire ? refill_data_i : in_data_i;
  assign rsp_error_o = retire ? refill_error_i : in_error_i;

  assign refill_valid_o = issue_found;
  assign refill_addr_o  = {issue_line, {LINE_ALIGN{1'b0}}};
  assign refill_id_o    = issue_idx;
  assign refill_ready_o = retire;

  assign write_valid_o = retire;
  assign write_addr_o  = ret_line[COUNT_ALIGN-1:0];
  assign write_tag_o   = ret_line[LINE_AW-1:COUNT_ALIGN];
  assign write_set_o   = evict_q;
  assign write_data_o  = refill_data_i;
  assign write_error_o = refill_error_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= '0;
      issued_q   <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
      for (int i = 0; i < PENDING_COUNT; i++) begin
        line_q[i] <= '0;
        id_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < PENDING_COUNT; i++) begin
        // a refill for an entry without an outstanding request leaves it alone
        if (retire && ret_sel[i] && valid_q[i] && issued_q[i]) begin
          valid_q[i]  <= 1'b0;
          issued_q[i] <= 1'b0;
        end else if (do_alloc && alloc_sel[i]) begin
          valid_q[i]  <= 1'b1;
          issued_q[i] <= 1'b0;
          line_q[i]   <= in_line;
          id_q[i]     <= in_id_i;
        end else begin
          if (issue_hs && (issue_idx == PENDING_IW'(i))) issued_q[i] <= 1'b1;
          if (do_merge && match_vec[i]) id_q[i] <= id_q[i] | in_id_i;
        end
      end
      hold_q     <= issue_found & ~refill_ready_i;
      hold_idx_q <= issue_idx;
    end
  end

  if (SET_COUNT > 1) begin : g_evict_counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        evict_q <= '0;
      end else if (retire) begin
        evict_q <= (evict_q == SET_ALIGN'(SET_COUNT - 1)) ? '0
                                                          : evict_q + SET_ALIGN'(1);
      end
    end
  end else begin : g_evict_fixed
    assign evict_q = '0;
  end

`ifndef SYNTHESIS
  refill_id_known : assert property (@(posedge clk_i) disable iff (!rst_ni)
    refill_valid_i |-> retire_known)
    else $error("refill_id_i names an entry without an outstanding refill");
`endif

endmodule

`default_nettype wire

// File: tb/tb_snitch_icache_miss_handler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_snitch_icache_miss_handler                                             |
// | Self-checking bench: table-driven hit vectors, directed multi-cycle       |
// | sequences, and randomized traffic against a line-level reference model.   |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module tb_snitch_icache_miss_handler;

  localparam snitch_icache_pkg::config_t TB_CFG = '{
    FETCH_AW: 32, ID_WIDTH: 4, LINE_WIDTH: 128, LINE_ALIGN: 4, COUNT_ALIGN: 4,
    SET_ALIGN: 1, SET_COUNT: 2, TAG_WIDTH: 24, PENDING_COUNT: 2
  };

  logic         clk;
  logic         rst_ni;
  logic [31:0]  in_addr_i;
  logic [3:0]   in_id_i;
  logic [0:0]   in_set_i;
  logic         in_hit_i;
  logic [127:0] in_data_i;
  logic         in_error_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [31:0]  rsp_addr_o;
  logic [3:0]   rsp_id_o;
  logic [127:0] rsp_data_o;
  logic         rsp_error_o;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic [31:0]  refill_addr_o;
  logic [0:0]   refill_id_o;
  logic         refill_valid_o;
  logic         refill_ready_i;
  logic [127:0] refill_data_i;
  logic         refill_error_i;
  logic [0:0]   refill_id_i;
  logic         refill_valid_i;
  logic         refill_ready_o;
  logic [3:0]   write_addr_o;
  logic [0:0]   write_set_o;
  logic [127:0] write_data_o;
  logic [23:0]  write_tag_o;
  logic         write_error_o;
  logic         write_valid_o;
  logic         write_ready_i;

  snitch_icache_miss_handler #(.CFG(TB_CFG)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_addr_i(in_addr_i), .in_id_i(in_id_i), .in_set_i(in_set_i), .in_hit_i(in_hit_i),
    .in_data_i(in_data_i), .in_error_i(in_error_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .rsp_addr_o(rsp_addr_o), .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o),
    .rsp_error_o(rsp_error_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .refill_addr_o(refill_addr_o), .refill_id_o(refill_id_o),
    .refill_valid_o(refill_valid_o), .refill_ready_i(refill_ready_i),
    .refill_data_i(refill_data_i), .refill_error_i(refill_error_i),
    .refill_id_i(refill_id_i), .refill_valid_i(refill_valid_i),
    .refill_ready_o(refill_ready_o),
    .write_addr_o(write_addr_o), .write_set_o(write_set_o), .write_data_o(write_data_o),
    .write_tag_o(write_tag_o), .write_error_o(write_error_o),
    .write_valid_o(write_valid_o), .write_ready_i(write_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_set = 0;

  localparam logic [127:0] PAT_A5 = {4{32'hA5A5_A5A5}};
  localparam logic [127:0] PAT_3C = {4{32'h3C3C_3C3C}};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    in_valid_i = 1'b0; in_hit_i = 1'b0; in_addr_i = '0; in_id_i = '0;
    in_set_i = '0; in_data_i = '0; in_error_i = 1'b0;
    rsp_ready_i = 1'b1; refill_ready_i = 1'b1; write_ready_i = 1'b1;
    refill_valid_i = 1'b0; refill_id_i = '0; refill_data_i = '0; refill_error_i = 1'b0;
  endtask

  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  task automatic miss(input logic [31:0] a, input logic [3:0] id);
    in_valid_i = 1'b1; in_hit_i = 1'b0; in_addr_i = a; in_id_i = id;
  endtask

  task automatic hit(input logic [31:0] a, input logic [3:0] id, input logic [127:0] d);
    in_valid_i = 1'b1; in_hit_i = 1'b1; in_addr_i = a; in_id_i = id; in_data_i = d;
  endtask

  task automatic refill(input logic id, input logic [127:0] d, input logic err);
    refill_valid_i = 1'b1; refill_id_i = id; refill_data_i = d; refill_error_i = err;
  endtask

  // checks the retire outputs and advances the expected eviction set
  task automatic chk_retire(input string name, input logic [3:0] mask, input logic [31:0] line_addr);
    check({name, " write_valid"}, write_valid_o, 1'b1);
    check({name, " rsp_valid"}, rsp_valid_o, 1'b1);
    check({name, " rsp_id"}, rsp_id_o, mask);
    check({name, " rsp_addr"}, rsp_addr_o, line_addr);
    check({name, " write_set"}, write_set_o, exp_set);
    exp_set = (exp_set + 1) % 2;
  endtask

  task automatic chk_quiet(input string name);
    check({name, " in_ready"}, in_ready_o, 1'b0);
    check({name, " rsp_valid"}, rsp_valid_o, 1'b0);
    check({name, " refill_valid"}, refill_valid_o, 1'b0);
    check({name, " refill_ready"}, refill_ready_o, 1'b0);
    check({name, " write_valid"}, write_valid_o, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_ni = 1'b0;
    #1;
    chk_quiet("in reset");
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk_quiet("after reset");
    exp_set = 0;
  endtask

  typedef struct {
    logic         vld;
    logic         hit;
    logic         rrdy;
    logic [31:0]  addr;
    logic [3:0]   id;
    logic [127:0] data;
    logic         err;
    logic         e_rsp_valid;
    logic         e_in_ready;
  } vec_t;

  // reference model state: one slot per pending line
  bit          m_v   [2];
  bit          m_iss [2];
  logic [27:0] m_line[2];
  logic [3:0]  m_id  [2];

  initial begin
    vec_t vecs[6];
    idle();
    rst_ni = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h0,         4'b0000, 128'h0,        1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h1000_0040, 4'b0001, PAT_3C,        1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h1000_0044, 4'b0010, PAT_A5,        1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h1234_5678, 4'b1010, 128'hDEAD_BEEF, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h1000_0040, 4'b0001, PAT_3C,        1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 4'b1000, ~PAT_A5,       1'b0, 1'b1, 1'b1};

    do_reset();

    // hits pass straight through with nothing pending
    for (int k = 0; k < 6; k++) begin
      nxt();
      in_valid_i = vecs[k].vld; in_hit_i = vecs[k].hit; rsp_ready_i = vecs[k].rrdy;
      in_addr_i = vecs[k].addr; in_id_i = vecs[k].id; in_data_i = vecs[k].data;
      in_error_i = vecs[k].err;
      #1;
      check($sformatf("vec%0d rsp_valid", k), rsp_valid_o, vecs[k].e_rsp_valid);
      check($sformatf("vec%0d in_ready", k), in_ready_o, vecs[k].e_in_ready);
      check($sformatf("vec%0d refill_valid", k), refill_valid_o, 1'b0);
      if (vecs[k].e_rsp_valid) begin
        check($sformatf("vec%0d rsp_addr", k), rsp_addr_o, vecs[k].addr);
        check($sformatf("vec%0d rsp_id", k), rsp_id_o, vecs[k].id);
        check($sformatf("vec%0d rsp_data", k), rsp_data_o, vecs[k].data);
        check($sformatf("vec%0d rsp_error", k), rsp_error_o, vecs[k].err);
      end
    end

    // miss and refill
    nxt(); miss(32'h2000_0010, 4'b0001); #1;
    check("t2 in_ready", in_ready_o, 1'b1);
    check("t2 no same-cycle refill", refill_valid_o, 1'b0);
    nxt(); #1;
    check("t2 refill_valid", refill_valid_o, 1'b1);
    check("t2 refill_addr", refill_addr_o, 32'h2000_0010);
    check("t2 refill_id", refill_id_o, 1'b0);
    nxt(); refill(1'b0, PAT_A5, 1'b0); #1;
    chk_retire("t2", 4'b0001, 32'h2000_0010);
    check("t2 refill_ready", refill_ready_o, 1'b1);
    check("t2 rsp_data", rsp_data_o, PAT_A5);
    check("t2 write_data", write_data_o, PAT_A5);
    check("t2 write_addr", write_addr_o, 4'h1);
    check("t2 write_tag", write_tag_o, 24'h20_0000);
    nxt(); #1;
    check("t2 idle refill_valid", refill_valid_o, 1'b0);
    check("t2 idle write_valid", write_valid_o, 1'b0);

    // coalescing: two misses on one line, one refill, merged response
    nxt(); miss(32'h3000_0000, 4'b0001); #1;
    check("t3 first in_ready", in_ready_o, 1'b1);
    nxt(); miss(32'h3000_0008, 4'b0100); #1;
    check("t3 merge in_ready", in_ready_o, 1'b1);
    check("t3 refill_id reused", refill_id_o, 1'b0);
    check("t3 refill_valid", refill_valid_o, 1'b1);
    nxt(); #1;
    check("t3 single refill", refill_valid_o, 1'b0);
    nxt(); refill(1'b0, PAT_3C, 1'b0); #1;
    chk_retire("t3", 4'b0101, 32'h3000_0000);

    // full table
    nxt(); miss(32'h5000_0000, 4'b0001); #1;
    check("t4 A in_ready", in_ready_o, 1'b1);
    nxt(); miss(32'h5000_0100, 4'b0010); #1;
    check("t4 B in_ready", in_ready_o, 1'b1);
    nxt(); miss(32'h5000_0200, 4'b1000); #1;
    check("t4 C stall", in_ready_o, 1'b0);
    check("t4 refill_id B", refill_id_o, 1'b1);
    nxt(); miss(32'h5000_0200, 4'b1000); #1;
    check("t4 C stall 2", in_ready_o, 1'b0);
    nxt(); miss(32'h5000_0200, 4'b1000); refill(1'b0, PAT_A5, 1'b0); #1;
    check("t4 C stall on retire", in_ready_o, 1'b0);
    chk_retire("t4 A", 4'b0001, 32'h5000_0000);
    nxt(); miss(32'h5000_0200, 4'b1000); #1;
    check("t4 C accepted", in_ready_o, 1'b1);
    nxt(); #1;
    check("t4 C refill_addr", refill_addr_o, 32'h5000_0200);
    check("t4 C refill_id", refill_id_o, 1'b0);
    nxt(); refill(1'b1, PAT_3C, 1'b0); #1;
    chk_retire("t4 B", 4'b0010, 32'h5000_0100);
    nxt(); refill(1'b0, PAT_3C, 1'b0); #1;
    chk_retire("t4 C", 4'b1000, 32'h5000_0200);

    // a refill request held by back-pressure keeps its payload
    nxt(); miss(32'h8000_0000, 4'b0001); #1;
    nxt(); miss(32'h8000_0010, 4'b0010); #1;
    nxt(); refill_ready_i = 1'b0; refill(1'b0, PAT_A5, 1'b0); #1;
    chk_retire("t7 P", 4'b0001, 32'h8000_0000);
    check("t7 present Q", refill_id_o, 1'b1);
    nxt(); refill_ready_i = 1'b0; miss(32'h8000_0020, 4'b0100); #1;
    check("t7 R in_ready", in_ready_o, 1'b1);
    nxt(); refill_ready_i = 1'b0; #1;
    check("t7 held id", refill_id_o, 1'b1);
    check("t7 held addr", refill_addr_o, 32'h8000_0010);
    nxt(); #1;
    check("t7 held accepted", refill_id_o, 1'b1);
    nxt(); #1;
    check("t7 R refill_id", refill_id_o, 1'b0);
    check("t7 R refill_addr", refill_addr_o, 32'h8000_0020);
    nxt(); refill(1'b1, PAT_A5, 1'b0); #1;
    chk_retire("t7 Q", 4'b0010, 32'h8000_0010);
    nxt(); refill(1'b0, PAT_A5, 1'b0); #1;
    chk_retire("t7 R", 4'b0100, 32'h8000_0020);

    // retire vs lookup input
    nxt(); miss(32'h6000_0000, 4'b0001); #1;
    nxt(); #1;
    check("t5 refill_valid", refill_valid_o, 1'b1);
    nxt(); rsp_ready_i = 1'b0; refill(1'b0, PAT_A5, 1'b0); hit(32'h1000_0040, 4'b0010, PAT_3C); #1;
    check("t5 no retire refill_ready", refill_ready_o, 1'b0);
    check("t5 no retire write_valid", write_valid_o, 1'b0);
    check("t5 hit in_ready blocked", in_ready_o, 1'b0);
    nxt(); refill(1'b0, PAT_A5, 1'b0); hit(32'h1000_0040, 4'b0010, PAT_3C); #1;
    check("t5 retire wins in_ready", in_ready_o, 1'b0);
    chk_retire("t5", 4'b0001, 32'h6000_0000);
    nxt(); hit(32'h1000_0040, 4'b0010, PAT_3C); #1;
    check("t5 hit in_ready", in_ready_o, 1'b1);
    check("t5 hit rsp_id", rsp_id_o, 4'b0010);
    check("t5 hit rsp_addr", rsp_addr_o, 32'h1000_0040);

    // eviction counter from reset and error propagation
    do_reset();
    for (int k = 0; k < 4; k++) begin
      nxt(); miss(32'h9000_0000 + 32'(k) * 32'h10, 4'b0001); #1;
      nxt(); #1;
      nxt(); refill(1'b0, PAT_A5, k[0]); #1;
      check($sformatf("t6 write_set %0d", k), write_set_o, k % 2);
      check($sformatf("t6 write_error %0d", k), write_error_o, k[0]);
      check($sformatf("t6 rsp_error %0d", k), rsp_error_o, k[0]);
    end
    nxt(); miss(32'hA000_0000, 4'b0001); #1;
    nxt(); miss(32'hA000_0100, 4'b0010); refill_ready_i = 1'b0; #1;
    nxt(); refill_ready_i = 1'b0; #1;
    check("t6 pending before reset", refill_valid_o, 1'b1);
    do_reset();
    nxt(); miss(32'hB000_0000, 4'b0001); #1;
    check("t6 post-reset in_ready", in_ready_o, 1'b1);
    nxt(); #1;
    check("t6 post-reset refill_id", refill_id_o, 1'b0);
    check("t6 post-reset refill_addr", refill_addr_o, 32'hB000_0000);

    // randomized traffic against the line-level model
    do_reset();
    for (int s = 0; s < 2; s++) begin
      m_v[s] = 1'b0; m_iss[s] = 1'b0; m_line[s] = '0; m_id[s] = '0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      int n_iss, pick, fr, mi, ri;
      bit e_ret, e_rdy, e_rv;
      logic [27:0] ln;
      nxt();
      rsp_ready_i   = ($urandom_range(0, 9) != 0);
      write_ready_i = ($urandom_range(0, 9) != 0);
      in_valid_i    = 1'($urandom_range(0, 1));
      in_hit_i      = ($urandom_range(0, 3) == 0);
      in_addr_i     = 32'h7000_0000 | (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
      in_id_i       = 4'b0001 << $urandom_range(0, 3);
      in_data_i     = {$urandom, $urandom, $urandom, $urandom};
      in_error_i    = 1'($urandom_range(0, 1));
      n_iss = 0;
      for (int s = 0; s < 2; s++) if (m_v[s] && m_iss[s]) n_iss++;
      pick = -1;
      if (n_iss > 0 && $urandom_range(0, 2) == 0) begin
        pick = $urandom_range(0, 1);
        if (!(m_v[pick] && m_iss[pick])) pick = 1 - pick;
        refill(1'(pick), {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
      end
      ln = in_addr_i[31:4];
      mi = -1; fr = -1; ri = -1;
      for (int s = 1; s >= 0; s--) begin
        if (m_v[s] && m_line[s] == ln) mi = s;
        if (!m_v[s]) fr = s;
        if (m_v[s] && !m_iss[s]) ri = s;
      end
      e_ret = refill_valid_i && write_ready_i && rsp_ready_i;
      e_rv  = (ri >= 0);
      if (e_ret || !in_valid_i) e_rdy = 1'b0;
      else if (in_hit_i)        e_rdy = rsp_ready_i;
      else                      e_rdy = (mi >= 0) || (fr >= 0);
      #1;
      check("rnd in_ready", in_ready_o, e_rdy);
      check("rnd rsp_valid", rsp_valid_o, e_ret || (in_valid_i && in_hit_i));
      check("rnd refill_ready", refill_ready_o, e_ret);
      check("rnd write_valid", write_valid_o, e_ret);
      check("rnd refill_valid", refill_valid_o, e_rv);
      if (e_rv) begin
        check("rnd refill_id", refill_id_o, ri);
        check("rnd refill_addr", refill_addr_o, {m_line[ri], 4'h0});
      end
      if (e_ret) begin
        check("rnd ret rsp_id", rsp_id_o, m_id[pick]);
        check("rnd ret rsp_addr", rsp_addr_o, {m_line[pick], 4'h0});
        check("rnd ret rsp_data", rsp_data_o, refill_data_i);
        check("rnd ret write_addr", write_addr_o, m_line[pick][3:0]);
        check("rnd ret write_tag", write_tag_o, m_line[pick][27:4]);
        check("rnd ret write_set", write_set_o, exp_set);
        check("rnd ret write_error", write_error_o, refill_error_i);
        m_v[pick] = 1'b0; m_iss[pick] = 1'b0;
        exp_set = (exp_set + 1) % 2;
      end else if (in_valid_i && in_hit_i) begin
        check("rnd hit rsp_addr", rsp_addr_o, in_addr_i);
        check("rnd hit rsp_id", rsp_id_o, in_id_i);
        check("rnd hit rsp_data", rsp_data_o, in_data_i);
      end
      if (e_rv) m_iss[ri] = 1'b1;
      if (e_rdy && !in_hit_i) begin
        if (mi >= 0) m_id[mi] = m_id[mi] | in_id_i;
        else begin
          m_v[fr] = 1'b1; m_iss[fr] = 1'b0; m_line[fr] = ln; m_id[fr] = in_id_i;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
